// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between the producer stages, the FIFO write/pop port and the write arbiter.
interface fifo_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int CNT_W = 4,
  parameter int GW    = $clog2(NREQ)
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_wen;
  logic [WIDTH-1:0]      fifo_wdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  cons_pop;
  logic                  fifo_pop;
  logic                  flush_req;
  logic                  flush_done;
  logic [CNT_W-1:0]      level;
  logic [GW-1:0]         grant_id;

  modport master (
    input  req_valid, req_data, fifo_full, fifo_empty, cons_pop, flush_req,
    output req_ready, fifo_wen, fifo_wdata, fifo_pop, flush_done, level, grant_id
  );

  modport slave (
    output req_valid, req_data, fifo_full, fifo_empty, cons_pop, flush_req,
    input  req_ready, fifo_wen, fifo_wdata, fifo_pop, flush_done, level, grant_id
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin sharer of the FIFO write port, with a shadow occupancy
// counter and a flush sequencer that drains the FIFO before pulsing done.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  fifo_wr_arbiter_if.master bus
);
  localparam int GW = $clog2(NREQ);

  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

  state_t           state;
  logic [GW-1:0]    last_grant;
  logic [CNT_W-1:0] level_q;
  logic             done_q;

  logic             found;
  logic [GW-1:0]    win;
  logic [GW-1:0]    idx;
  logic             wr;
  logic             pop;
  logic             rd;
  logic [WIDTH-1:0] wdata;
  logic [NREQ-1:0]  ready;

  // Rotating priority search starting just after the last accepted requester.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = GW'((int'(last_grant) + k) % NREQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Writes only happen in RUN with room in the FIFO; reset masks all strobes.
  assign wr  = !rst && (state == RUN) && !bus.fifo_full && found;
  assign pop = !rst && ((state == RUN) ? bus.cons_pop : (state == FLUSH));
  assign rd  = pop && !bus.fifo_empty;

  // Winner's data and one-hot ready; everything zero when nothing is written.
  always_comb begin
    wdata = '0;
    ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (wr && (win == GW'(i))) begin
        wdata    = bus.req_data[i*WIDTH +: WIDTH];
        ready[i] = 1'b1;
      end
    end
  end

  assign bus.fifo_wen   = wr;
  assign bus.fifo_wdata = wdata;
  assign bus.req_ready  = ready;
  assign bus.fifo_pop   = pop;
  assign bus.flush_done = done_q;
  assign bus.level      = level_q;
  assign bus.grant_id   = last_grant;

  // Grant pointer and saturating shadow level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GW'(NREQ - 1);
      level_q    <= '0;
    end else begin
      if (wr) last_grant <= win;
      if (wr && !rd && (level_q != CNT_W'(DEPTH))) level_q <= level_q + 1'b1;
      else if (rd && !wr && (level_q != '0))       level_q <= level_q - 1'b1;
    end
  end

  // Flush sequencer: RUN -> FLUSH on request, DONE once empty, back to RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        RUN:     if (bus.flush_req) state <= FLUSH;
        FLUSH:   if (bus.fifo_empty) begin
                   state  <= DONE;
                   done_q <= 1'b1;
                 end
        DONE:    state <= RUN;
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: FIFO occupancy model plus a write scoreboard.
module tb_fifo_wr_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  int   m_cnt = 0;
  int   m_st = 0;
  int   m_last = NREQ - 1;
  exp_t sb[$];

  fifo_wr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .CNT_W(CNT_W)) bus();

  fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.fifo_full  = (m_cnt == DEPTH);
  assign bus.fifo_empty = (m_cnt == 0);

  // One clock of stimulus: predict, sample at negedge, compare, advance model.
  task automatic step(output int g, output bit pd, output bit fd);
    int   exp_id;
    bit   exp_pop;
    bit   was_empty;
    exp_t e;
    for (int i = 0; i < NREQ; i++) bus.req_data[i*WIDTH +: WIDTH] = $urandom;
    @(negedge clk);
    exp_id = -1;
    if (m_st == 0 && m_cnt < DEPTH)
      for (int k = 1; k <= NREQ; k++)
        if (exp_id < 0 && bus.req_valid[(m_last + k) % NREQ]) exp_id = (m_last + k) % NREQ;
    if (exp_id >= 0) begin
      e.id = exp_id;
      e.d  = bus.req_data[exp_id*WIDTH +: WIDTH];
      sb.push_back(e);
    end
    exp_pop = (m_st == 0) ? bus.cons_pop : (m_st == 1);
    g = -1;
    for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) g = i;
    pd = bus.fifo_pop && !bus.fifo_empty;
    fd = bus.flush_done;

    checks++;
    if (bus.fifo_wen === 1'b1) begin
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_write: unexpected write ready=%b", bus.req_ready);
      end else begin
        e = sb.pop_front();
        if (bus.req_ready !== (NREQ'(1) << e.id) || bus.fifo_wdata !== e.d) begin
          failures++;
          $display("FAIL sb_write: ready=%b data=%h expected ready=%b data=%h",
                   bus.req_ready, bus.fifo_wdata, NREQ'(1) << e.id, e.d);
        end
      end
    end else begin
      if (sb.size() != 0 || bus.req_ready !== '0 || bus.fifo_wen !== 1'b0) begin
        failures++;
        $display("FAIL sb_nowrite: wen=%b ready=%b expected write id=%0d",
                 bus.fifo_wen, bus.req_ready, exp_id);
        sb.delete();
      end
    end
    checks++;
    if (bus.fifo_pop !== exp_pop) begin
      failures++;
      $display("FAIL pop: got %b expected %b", bus.fifo_pop, exp_pop);
    end
    checks++;
    if (bus.level !== CNT_W'(m_cnt) || bus.level > DEPTH) begin
      failures++;
      $display("FAIL level: got %0d expected %0d", bus.level, m_cnt);
    end
    checks++;
    if (bus.flush_done !== (m_st == 2) || bus.grant_id !== 2'(m_last)) begin
      failures++;
      $display("FAIL done_gid: done=%b gid=%0d expected done=%b gid=%0d",
               bus.flush_done, bus.grant_id, m_st == 2, m_last);
    end

    @(posedge clk);
    #1;
    was_empty = (m_cnt == 0);
    if (exp_id >= 0) begin
      m_cnt++;
      m_last = exp_id;
    end
    if (exp_pop && !was_empty) m_cnt--;
    case (m_st)
      0: if (bus.flush_req) m_st = 1;
      1: if (was_empty) m_st = 2;
      default: m_st = 0;
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.cons_pop  = 1'b0;
    bus.flush_req = 1'b0;
    m_cnt = 0;
    m_st = 0;
    m_last = NREQ - 1;
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    bus.cons_pop  = 1'b1;
    bus.flush_req = 1'b1;
    bus.req_data  = '1;
    #13;
    checks++;
    if (bus.req_ready !== 4'b0000 || bus.fifo_wen !== 1'b0 || bus.fifo_pop !== 1'b0) begin
      failures++;
      $display("FAIL reset_strobes: ready=%b wen=%b pop=%b expected 0", bus.req_ready, bus.fifo_wen, bus.fifo_pop);
    end
    checks++;
    if (bus.level !== 4'd0 || bus.flush_done !== 1'b0 || bus.grant_id !== 2'd3) begin
      failures++;
      $display("FAIL reset_state: level=%0d done=%b gid=%0d expected 0 0 3", bus.level, bus.flush_done, bus.grant_id);
    end
    do_reset();
  endtask

  task automatic test_single();
    int g; bit pd, fd;
    do_reset();
    bus.req_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step(g, pd, fd);
      checks++;
      if (g !== 0 || bus.level !== CNT_W'(i + 1)) begin
        failures++;
        $display("FAIL single: grant=%0d level=%0d expected grant=0 level=%0d", g, bus.level, i + 1);
      end
    end
    checks++;
    if (bus.grant_id !== 2'd0) begin
      failures++;
      $display("FAIL single_gid: got %0d expected 0", bus.grant_id);
    end
  endtask

  task automatic test_round_robin();
    int g; bit pd, fd;
    int ord[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    do_reset();
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step(g, pd, fd);
      checks++;
      if (g !== ord[i]) begin
        failures++;
        $display("FAIL rr_order: slot %0d grant=%0d expected %0d", i, g, ord[i]);
      end
    end
    step(g, pd, fd);
    checks++;
    if (g !== -1 || bus.level !== 4'd8) begin
      failures++;
      $display("FAIL rr_full: grant=%0d level=%0d expected none level=8", g, bus.level);
    end
  endtask

  task automatic test_simul();
    int g; bit pd, fd;
    bus.req_valid = 4'b0001;
    bus.cons_pop  = 1'b1;
    step(g, pd, fd);
    checks++;
    if (g !== -1 || bus.level !== 4'd7) begin
      failures++;
      $display("FAIL full_pop: grant=%0d level=%0d expected none level=7", g, bus.level);
    end
    bus.req_valid = 4'b0000;
    repeat (2) step(g, pd, fd);
    bus.req_valid = 4'b0001;
    step(g, pd, fd);
    checks++;
    if (g !== 0 || bus.level !== 4'd5) begin
      failures++;
      $display("FAIL wr_pop: grant=%0d level=%0d expected grant=0 level=5", g, bus.level);
    end
    bus.req_valid = 4'b0000;
    bus.cons_pop  = 1'b0;
  endtask

  task automatic test_wrap();
    int g; bit pd, fd;
    int ord[3] = '{0, 1, 0};
    do_reset();
    bus.req_valid = 4'b0111;
    repeat (3) step(g, pd, fd);
    bus.req_valid = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      step(g, pd, fd);
      checks++;
      if (g !== ord[i]) begin
        failures++;
        $display("FAIL wrap: slot %0d grant=%0d expected %0d", i, g, ord[i]);
      end
    end
  endtask

  task automatic test_flush();
    int g; bit pd, fd;
    int pops = 0, dones = 0, bad_rdy = 0, n = 0;
    do_reset();
    bus.req_valid = 4'b0001;
    repeat (4) step(g, pd, fd);
    bus.req_valid = 4'b0000;
    bus.flush_req = 1'b1;
    step(g, pd, fd);
    bus.flush_req = 1'b0;
    bus.req_valid = 4'b1111;
    while (dones == 0 && n < 20) begin
      step(g, pd, fd);
      n++;
      if (g >= 0) bad_rdy++;
      if (pd) pops++;
      if (fd) dones++;
    end
    checks++;
    if (dones != 1 || pops != 4 || bad_rdy != 0 || bus.level !== 4'd0) begin
      failures++;
      $display("FAIL flush: done=%0d pops=%0d grants=%0d level=%0d expected 1 4 0 0",
               dones, pops, bad_rdy, bus.level);
    end
    step(g, pd, fd);
    checks++;
    if (fd !== 1'b0 || g !== 1) begin
      failures++;
      $display("FAIL flush_resume: done=%b grant=%0d expected 0 and 1", fd, g);
    end
    bus.req_valid = 4'b0000;
  endtask

  task automatic test_reset_mid_flush();
    int g; bit pd, fd;
    do_reset();
    bus.req_valid = 4'b0001;
    repeat (4) step(g, pd, fd);
    bus.req_valid = 4'b0000;
    bus.flush_req = 1'b1;
    step(g, pd, fd);
    bus.flush_req = 1'b0;
    bus.req_valid = 4'b1111;
    repeat (2) step(g, pd, fd);
    checks++;
    if (bus.level !== 4'd2) begin
      failures++;
      $display("FAIL midflush_level: got %0d expected 2", bus.level);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000 || bus.fifo_wen !== 1'b0 || bus.fifo_pop !== 1'b0 ||
        bus.level !== 4'd0 || bus.flush_done !== 1'b0) begin
      failures++;
      $display("FAIL midflush_rst: ready=%b wen=%b pop=%b level=%0d done=%b expected all 0",
               bus.req_ready, bus.fifo_wen, bus.fifo_pop, bus.level, bus.flush_done);
    end
    do_reset();
    bus.req_valid = 4'b1111;
    step(g, pd, fd);
    checks++;
    if (g !== 0 || fd !== 1'b0) begin
      failures++;
      $display("FAIL midflush_resume: grant=%0d done=%b expected 0 0", g, fd);
    end
    step(g, pd, fd);
    bus.req_valid = 4'b0000;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.cons_pop  = 1'b0;
    bus.flush_req = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_simul();
    test_wrap();
    test_flush();
    test_reset_mid_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the pipeline FIFO among NREQ producers. Producers use a valid/ready handshake.
- Tracks FIFO occupancy in a shadow level counter.
- Sequences a flush: drains the FIFO by forcing pops until it is empty, then pulses done.
- Sits between the pipeline stages that produce entries and the FIFO's wen/wData/pop/isFull/isEmpty port.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 32, data width of one FIFO entry
- DEPTH, 8, FIFO depth; must equal the attached FIFO's depth
- CNT_W, 4, level counter width, = clog2(DEPTH)+1

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  bit i: requester i presents data
- req_data  in  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH]
- req_ready  out  NREQ  one-hot; bit i: requester i's data is written this cycle
- fifo_wen  out  1  FIFO write enable
- fifo_wdata  out  WIDTH  FIFO write data
- fifo_full  in  1  FIFO isFull
- fifo_empty  in  1  FIFO isEmpty
- cons_pop  in  1  consumer pop request
- fifo_pop  out  1  pop driven to FIFO
- flush_req  in  1  level-sampled flush request
- flush_done  out  1  one-cycle pulse when a flush completes
- level  out  CNT_W  current FIFO occupancy, 0..DEPTH
- grant_id  out  clog2(NREQ)  index of the last accepted requester

Behaviour:
- Reset (rst=1, asynchronous):
  - state=RUN, last_grant=NREQ-1 (requester 0 has top priority first), level=0, flush_done=0, grant_id=NREQ-1.
  - While rst is high, req_ready=0, fifo_wen=0 and fifo_pop=0, regardless of inputs.
- FSM states: RUN, FLUSH, DONE.
  - RUN -> FLUSH when flush_req=1 at a clock edge.
  - FLUSH -> DONE at the edge where fifo_empty=1.
  - DONE -> RUN unconditionally after one cycle; flush_done=1 only in DONE.
  - A flush_req seen in DONE is ignored; flush_req is re-sampled only in RUN.
- Arbitration (combinational, RUN only, fifo_full=0):
  - Search from (last_grant+1) mod NREQ upward with wrap-around. The first i with req_valid[i]=1 wins.
  - Winner gets req_ready[i]=1, fifo_wen=1, fifo_wdata=req_data[i]. If there is no winner, all three are 0.
  - fifo_full=1 or state!=RUN: req_ready=0 and fifo_wen=0. Requesters hold valid and data, and no data is dropped.
- Write acceptance: wr = fifo_wen. On the edge with wr=1, last_grant and grant_id take the winner index.
- fifo_pop = cons_pop in RUN, 1 in FLUSH, 0 in DONE.
- Level arithmetic. Define rd = fifo_pop & ~fifo_empty. Then on each edge:
  - wr & ~rd: level+1
  - rd & ~wr: level-1
  - both or neither: unchanged
  - level never exceeds DEPTH and never drops below 0. The bench asserts this; the RTL saturates as a guard.
- Latency: zero-cycle grant (ready is in the same cycle as valid); level updates one edge after the transfer.
- Simultaneous write and pop on a full FIFO: no write, because fifo_full gates it. Pop proceeds and level decrements.
- Reset mid-flush returns to RUN with level=0 and no flush_done pulse.

Test Plan:
- Single requester: req_valid=0001 for 3 cycles, FIFO not full -> req_ready=0001 each cycle, 3 writes, level 0->1->2->3, grant_id=0.
- Round-robin fairness: req_valid=1111 held 8 cycles, no pops -> grant order 0,1,2,3,0,1,2,3; level=8; fifo_full then rises, so ready=0000 on the 9th cycle and level holds at 8.
- Wrap-around skip: last_grant=2, req_valid=0011 -> requester 0 granted, then requester 1, then requester 0.
- Simultaneous write and pop at level=5: one write + cons_pop=1 -> level stays 5. At level=8 (full) with cons_pop=1 and valid=1 -> no write, level 7.
- Flush: level=4, flush_req pulse -> fifo_pop=1 for 4 cycles, req_ready=0 throughout, level 4->0, flush_done high exactly one cycle, then RUN and grants resume.
- Async reset asserted mid-flush at level=2 -> outputs 0 immediately; after release, level=0, state RUN, first grant goes to requester 0.
